regfile_write_bank: RTL and testbench

Eight-entry 16-bit general-purpose register bank holding the write side of the datapath register file. It decodes a 3-bit register address and demultiplexes one write per cycle into R0–R7. It also sequences load-multiple (LM) bursts from an 8-bit register mask with a valid/ready handshake, and auto-increments R7 (the PC). All eight registers are driven out in parallel as the data inputs of the 8:1 read-select mux feeding the ALU and memory paths.

---
 rtl/regfile_write_bank.sv | 124 ++++++++++++
 tb/tb_regfile_write_bank.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/regfile_write_bank.sv
// Eight-entry write bank for the datapath register file: single writes, LM burst
// sequencing from a register mask, and R7 (PC) auto-increment.
//
//  state | meaning
//  ------+----------------------------------------------------------
//  IDLE  | single writes and lm_start accepted
//  BURST | one LM beat per accepted handshake, lowest pending bit first
module regfile_write_bank #(
   parameter int unsigned WIDTH    = 16,
   parameter logic [WIDTH-1:0] PC_RESET = '0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             wr_en,
   input  logic [2:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pc_inc,
   input  logic             lm_start,
   input  logic [7:0]       lm_mask,
   input  logic [WIDTH-1:0] lm_data,
   input  logic             lm_valid,
   output logic             lm_ready,
   output logic [2:0]       lm_addr,
   output logic             lm_busy,
   output logic             lm_done,
   output logic [WIDTH-1:0] data0,
   output logic [WIDTH-1:0] data1,
   output logic [WIDTH-1:0] data2,
   output logic [WIDTH-1:0] data3,
   output logic [WIDTH-1:0] data4,
   output logic [WIDTH-1:0] data5,
   output logic [WIDTH-1:0] data6,
   output logic [WIDTH-1:0] data7
);

   localparam logic IDLE  = 1'b0;
   localparam logic BURST = 1'b1;

   logic             state;
   logic [7:0]       pending;
   logic             done_q;
   logic [WIDTH-1:0] regs [0:7];

   logic [7:0]       wr_sel;
   logic [WIDTH-1:0] wr_val;
   logic             beat;
   logic [7:0]       pending_nx;

   // Lowest set bit of pending wins; decoded only from registered state.
   always_comb begin
      lm_addr = 3'd0;
      if (state == BURST) begin
         for (int i = 7; i >= 0; i--) begin
            if (pending[i]) lm_addr = 3'(i);
         end
      end
   end

   assign lm_busy    = (state == BURST);
   assign lm_ready   = (state == BURST);
   assign lm_done    = done_q;
   assign beat       = lm_ready & lm_valid;
   assign pending_nx = pending & ~(8'd1 << lm_addr);

   always_comb begin
      wr_sel = 8'd0;
      wr_val = wr_data;
      if (state == IDLE && wr_en) begin
         wr_sel[wr_addr] = 1'b1;
      end else if (beat) begin
         wr_sel[lm_addr] = 1'b1;
         wr_val          = lm_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= IDLE;
         pending <= 8'd0;
         done_q  <= 1'b0;
         for (int i = 0; i < 7; i++) regs[i] <= '0;
         regs[7] <= PC_RESET;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (lm_start) begin
                  if (lm_mask != 8'd0) begin
                     pending <= lm_mask;
                     state   <= BURST;
                  end else begin
                     done_q  <= 1'b1;
                  end
               end
            end
            default: begin
               if (beat) begin
                  pending <= pending_nx;
                  if (pending_nx == 8'd0) begin
                     state  <= IDLE;
                     done_q <= 1'b1;
                  end
               end
            end
         endcase

         for (int i = 0; i < 8; i++) begin
            if (wr_sel[i]) regs[i] <= wr_val;
         end
         // An explicit R7 write overrides the PC increment.
         if (pc_inc && !wr_sel[7]) regs[7] <= regs[7] + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign data0 = regs[0];
   assign data1 = regs[1];
   assign data2 = regs[2];
   assign data3 = regs[3];
   assign data4 = regs[4];
   assign data5 = regs[5];
   assign data6 = regs[6];
   assign data7 = regs[7];

endmodule

// File: tb/tb_regfile_write_bank.sv
// Directed bench for regfile_write_bank: single writes, PC increment/wrap,
// LM bursts with stalls, empty-mask start and mid-burst reset.
module tb_regfile_write_bank;

   localparam logic [15:0] PC_RST = 16'h0100;

   logic        clk = 1'b0;
   logic        resetn;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic        pc_inc;
   logic        lm_start;
   logic [7:0]  lm_mask;
   logic [15:0] lm_data;
   logic        lm_valid;
   logic        lm_ready;
   logic [2:0]  lm_addr;
   logic        lm_busy;
   logic        lm_done;
   logic [15:0] data0, data1, data2, data3, data4, data5, data6, data7;
   logic [15:0] d [0:7];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign d[0] = data0; assign d[1] = data1; assign d[2] = data2; assign d[3] = data3;
   assign d[4] = data4; assign d[5] = data5; assign d[6] = data6; assign d[7] = data7;

   regfile_write_bank #(.WIDTH(16), .PC_RESET(PC_RST)) dut (
      .clk(clk), .resetn(resetn),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .pc_inc(pc_inc),
      .lm_start(lm_start), .lm_mask(lm_mask), .lm_data(lm_data), .lm_valid(lm_valid),
      .lm_ready(lm_ready), .lm_addr(lm_addr), .lm_busy(lm_busy), .lm_done(lm_done),
      .data0(data0), .data1(data1), .data2(data2), .data3(data3),
      .data4(data4), .data5(data5), .data6(data6), .data7(data7)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      for (int i = 0; i < 7; i++) check($sformatf("%s r%0d", tag, i), d[i], 16'h0000);
      check({tag, " r7"},    data7,    PC_RST);
      check({tag, " busy"},  lm_busy,  1'b0);
      check({tag, " ready"}, lm_ready, 1'b0);
      check({tag, " done"},  lm_done,  1'b0);
      check({tag, " addr"},  lm_addr,  3'd0);
   endtask

   initial begin
      resetn = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0;
      pc_inc = 1'b0; lm_start = 1'b0; lm_mask = 8'h0; lm_data = 16'h0; lm_valid = 1'b0;
      step(); step();
      resetn = 1'b1;
      check_reset_state("reset");

      // single writes
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
      step();
      check("wr r3", data3, 16'hBEEF);
      check("wr r0 untouched", data0, 16'h0000);
      wr_addr = 3'd0; wr_data = 16'h1234;
      step();
      check("wr r0", data0, 16'h1234);
      check("wr r3 kept", data3, 16'hBEEF);
      check("wr r7 kept", data7, PC_RST);
      check("wr r1 kept", data1, 16'h0000);

      // PC wrap and explicit-write priority
      wr_addr = 3'd7; wr_data = 16'hFFFF;
      step();
      wr_en = 1'b0; pc_inc = 1'b1;
      step();
      check("pc wrap", data7, 16'h0000);
      wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h0050;
      step();
      check("pc vs wr", data7, 16'h0050);
      wr_en = 1'b0;
      step();
      check("pc inc", data7, 16'h0051);
      pc_inc = 1'b0;

      // LM burst, mask 1010_0100, stall between beats 1 and 2
      lm_start = 1'b1; lm_mask = 8'b1010_0100;
      step();
      lm_start = 1'b0;
      check("lm busy", lm_busy, 1'b1);
      check("lm ready", lm_ready, 1'b1);
      check("lm addr0", lm_addr, 3'd2);
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hDEAD;
      lm_valid = 1'b1; lm_data = 16'hA001;
      step();
      wr_en = 1'b0;
      check("lm r2", data2, 16'hA001);
      check("lm addr1", lm_addr, 3'd5);
      check("lm wr ignored", data3, 16'hBEEF);
      lm_valid = 1'b0;
      step(); step();
      check("stall addr", lm_addr, 3'd5);
      check("stall busy", lm_busy, 1'b1);
      check("stall done", lm_done, 1'b0);
      check("stall r5", data5, 16'h0000);
      lm_valid = 1'b1; lm_data = 16'hA002;
      step();
      check("lm r5", data5, 16'hA002);
      check("lm addr2", lm_addr, 3'd7);
      check("lm done early", lm_done, 1'b0);
      lm_data = 16'hA003;
      step();
      lm_valid = 1'b0;
      check("lm r7", data7, 16'hA003);
      check("lm done", lm_done, 1'b1);
      check("lm busy end", lm_busy, 1'b0);
      check("lm ready end", lm_ready, 1'b0);
      step();
      check("lm done 1cyc", lm_done, 1'b0);
      check("lm r0 kept", data0, 16'h1234);

      // empty mask
      lm_start = 1'b1; lm_mask = 8'h00;
      step();
      lm_start = 1'b0;
      check("empty done", lm_done, 1'b1);
      check("empty busy", lm_busy, 1'b0);
      step();
      check("empty done off", lm_done, 1'b0);
      check("empty busy off", lm_busy, 1'b0);
      check("empty r2", data2, 16'hA001);
      check("empty r7", data7, 16'hA003);

      // mid-burst reset
      lm_start = 1'b1; lm_mask = 8'hFF;
      step();
      lm_start = 1'b0;
      lm_valid = 1'b1; lm_data = 16'hC0DE;
      step();
      lm_valid = 1'b0;
      check("abort r0", data0, 16'hC0DE);
      check("abort addr", lm_addr, 3'd1);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      check_reset_state("abort");
      step();
      check("abort no done", lm_done, 1'b0);

      lm_start = 1'b1; lm_mask = 8'h01;
      step();
      lm_start = 1'b0;
      check("post busy", lm_busy, 1'b1);
      check("post addr", lm_addr, 3'd0);
      lm_valid = 1'b1; lm_data = 16'h5555;
      step();
      lm_valid = 1'b0;
      check("post r0", data0, 16'h5555);
      check("post done", lm_done, 1'b1);
      check("post busy end", lm_busy, 1'b0);
      check("post r7", data7, PC_RST);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
